// File: rtl/mux_cont_2to1.sv
// WIDTH-bit 2:1 conditional mux. Built on the ?: operator so an unknown select
// leaves known only the bits on which both inputs agree.
module mux_cont_2to1 #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    input  logic             sel,
    output logic [WIDTH-1:0] o
);

    assign o = sel ? i1 : i0;

endmodule

// File: rtl/mux_cont.sv
// 4:1 mux of WIDTH-bit words: combinational output y plus a registered copy y_q.
// The mux tree is s1 at the first level and s2 at the second, giving s2 ? (s1 ? d : c) : (s1 ? b : a).
module mux_cont #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  logic             s1,
    input  logic             s2,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_q
);

    logic [WIDTH-1:0] ab_sel;
    logic [WIDTH-1:0] cd_sel;
    logic [WIDTH-1:0] y_d;

    mux_cont_2to1 #(.WIDTH(WIDTH)) u_mux_ab (
        .i0  (a),
        .i1  (b),
        .sel (s1),
        .o   (ab_sel)
    );

    mux_cont_2to1 #(.WIDTH(WIDTH)) u_mux_cd (
        .i0  (c),
        .i1  (d),
        .sel (s1),
        .o   (cd_sel)
    );

    mux_cont_2to1 #(.WIDTH(WIDTH)) u_mux_out (
        .i0  (ab_sel),
        .i1  (cd_sel),
        .sel (s2),
        .o   (y_d)
    );

    // y never depends on clk or rst_n, so it stays valid while reset is held.
    assign y = y_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q <= '0;
        end else begin
            y_q <= y_d;
        end
    end

endmodule

// File: tb/tb_mux_cont.sv
// Directed bench for mux_cont: expected values go into a scoreboard queue when
// stimulus is applied and are popped when the corresponding output is sampled.
module tb_mux_cont;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] a, b, c, d;
    logic             s1, s2;
    logic [WIDTH-1:0] y, y_q;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] sel_data[4];

    mux_cont #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .c     (c),
        .d     (d),
        .s1    (s1),
        .s2    (s2),
        .y     (y),
        .y_q   (y_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // Pop the oldest expected value and compare it with an observed output.
    task automatic check(input string tag, input logic [WIDTH-1:0] obs);
        logic [WIDTH-1:0] expv;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: observed=%h expected=<scoreboard empty>", tag, obs);
        end else begin
            expv = exp_q.pop_front();
            assert (obs === expv) else begin
                n_fail++;
                $error("FAIL %s: observed=%b expected=%b", tag, obs, expv);
            end
            $display("cmp %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, expv);
        end
        $display("cmp %s observed=%b expected=%b", tag, obs, expv);
    endtask

    initial begin
        rst_n = 1'b0;
        a = 4'hA; b = 4'hB; c = 4'hC; d = 4'hD;
        sel_data[0] = 4'hA; sel_data[1] = 4'hB;
        sel_data[2] = 4'hC; sel_data[3] = 4'hD;
        #1;
        exp_q.push_back(4'h0);
        check("reset_yq", y_q);

        // Selects left undriven: every candidate has MSB 1, so y[3] is known.
        check_bit("xsel_y_msb", y[3], 1'b1);

        // Combinational select map, no clock edge needed, reset still held.
        for (int i = 0; i < 4; i++) begin
            {s2, s1} = 2'(i);
            exp_q.push_back(sel_data[i]);
            #10;
            check($sformatf("comb_y_sel%0d", i), y);
        end
        exp_q.push_back(4'h0);
        check("yq_held_in_reset", y_q);

        // Registered path: one select step per cycle, y_q one cycle behind y.
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            {s2, s1} = 2'(i);
            exp_q.push_back(sel_data[i]);
            #1;
            check($sformatf("reg_y_sel%0d", i), y);
            exp_q.push_back(sel_data[i]);
            @(negedge clk);
            check($sformatf("reg_yq_sel%0d", i), y_q);
        end

        // Asynchronous reset pulse between edges while y_q = D.
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.push_back(4'h0);
        check("async_rst_yq", y_q);
        exp_q.push_back(4'hD);
        check("async_rst_y", y);
        @(posedge clk);
        #1;
        exp_q.push_back(4'h0);
        check("rst_low_edge_yq", y_q);
        exp_q.push_back(4'hD);
        check("rst_low_edge_y", y);

        // Release with select 01: first capture on the next rising edge.
        @(negedge clk);
        {s2, s1} = 2'b01;
        rst_n = 1'b1;
        #1;
        exp_q.push_back(4'h0);
        check("release_pre_edge_yq", y_q);
        @(posedge clk);
        #1;
        exp_q.push_back(4'hB);
        check("release_first_yq", y_q);

        // Select 11, then change d mid-cycle.
        @(negedge clk);
        {s2, s1} = 2'b11;
        #2;
        d = 4'h3;
        #1;
        exp_q.push_back(4'h3);
        check("d_change_y", y);
        exp_q.push_back(4'hB);
        check("d_change_yq_pending", y_q);
        @(posedge clk);
        #1;
        exp_q.push_back(4'h3);
        check("d_change_yq", y_q);

        // Unselected inputs must not disturb y.
        a = 4'h1; b = 4'h2; c = 4'h7;
        #1;
        exp_q.push_back(4'h3);
        check("unselected_change_y", y);
        @(posedge clk);
        #1;
        exp_q.push_back(4'h3);
        check("unselected_change_yq", y_q);

        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: observed=%0d expected=0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
